// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared FSM state, BRESP codes and counter helpers
// for the AXI4-Lite write arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    RESP      = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         ERR_CNT_W   = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(
    input logic [ERR_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, lowest index at or
// above ptr first, then wrapping to index 0.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && i >= int'(ptr)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/axil_write_arbiter.sv
// axil_write_arbiter: shares one AXI4-Lite write master among
// NUM_REQ single-beat requesters, one write in flight at a time.
module axil_write_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ            = 2,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [1:0]                      rsp_resp,
  output logic [7:0]                      err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]                      m_awprot,
  output logic                            m_awvalid,
  input  logic                            m_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic                            m_wvalid,
  input  logic                            m_wready,
  input  logic [1:0]                      m_bresp,
  input  logic                            m_bvalid,
  output logic                            m_bready
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [AW-1:0]        awaddr_q, awaddr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 awvalid_q, awvalid_d;
  logic                 wvalid_q, wvalid_d;
  logic                 bready_q, bready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [1:0]           rsp_resp_q, rsp_resp_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic               arb_en;
  logic [AW-1:0]      addr_sel;
  logic [DW-1:0]      data_sel;
  logic               aw_done;
  logic               w_done;

  // No grants while reset is held, so req_ready reads 0 in reset.
  assign arb_en = aresetn && (state_q == IDLE);

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en),
    .grant (grant),
    .idx   (gidx)
  );

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        addr_sel = req_addr[i*AW +: AW];
        data_sel = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    rsp_valid_d = '0;
    rsp_resp_d  = rsp_resp_q;
    err_d       = err_q;
    aw_done     = !awvalid_q || m_awready;
    w_done      = !wvalid_q || m_wready;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          gnt_d     = gidx;
          ptr_d     = (int'(gidx) == NUM_REQ-1) ? '0
                                                : gidx + 1'b1;
          awaddr_d  = addr_sel;
          wdata_d   = data_sel;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        awvalid_d = !aw_done;
        wvalid_d  = !w_done;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (m_bvalid && bready_q) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_resp_d         = m_bresp;
          bready_d           = 1'b0;
          if (m_bresp != RESP_OKAY) err_d = sat_inc(err_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_resp_q  <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_resp_q  <= rsp_resp_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_q;
  assign m_awaddr  = awaddr_q;
  assign m_awprot  = 3'b000;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;

endmodule

// File: doc/axil_write_arbiter.md
# axil_write_arbiter

Round-robin arbiter and sequencer that shares one AXI4-Lite write master port between NUM_REQ local requesters. Each requester presents a single-beat address/data write. The block grants one requester at a time, drives the AW/W/B handshakes toward the slave, and returns the write response to the granted requester. It sits between local write sources and the AXI4-Lite slave register file, and keeps a saturating count of error responses.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- C_M_AXI_DATA_WIDTH, 32, AXI data width
- C_M_AXI_ADDR_WIDTH, 4, AXI address width

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*C_M_AXI_ADDR_WIDTH  packed addresses; requester i at bits [i*AW +: AW]
- req_data  in  NUM_REQ*C_M_AXI_DATA_WIDTH  packed write data; same packing
- req_ready  out  NUM_REQ  one-hot acceptance pulse
- rsp_valid  out  NUM_REQ  one-hot response-done pulse
- rsp_resp  out  2  BRESP of the completed write; valid when any rsp_valid bit is high
- err_count  out  8  saturating count of responses with BRESP != 2'b00
- m_awaddr  out  C_M_AXI_ADDR_WIDTH  AXI write address
- m_awprot  out  3  tied to 3'b000
- m_awvalid  out  1
- m_awready  in  1
- m_wdata  out  C_M_AXI_DATA_WIDTH  AXI write data
- m_wvalid  out  1
- m_wready  in  1
- m_bresp  in  2
- m_bvalid  in  1
- m_bready  out  1

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - ADDR_DATA: AW and W are being offered to the slave.
  - RESP: waiting for the write response.
- IDLE:
  - If any req_valid bit is high, the round-robin arbiter selects grant g.
  - The search starts at priority pointer ptr and wraps upward.
  - req_ready[g] is high combinationally in that same cycle.
  - On the clock edge, req_addr[g] and req_data[g] are registered into m_awaddr and m_wdata, m_awvalid and m_wvalid are set, and the state moves to ADDR_DATA.
  - ptr updates to (g+1) mod NUM_REQ.
- ADDR_DATA:
  - m_awvalid clears on the edge after the cycle in which m_awvalid&m_awready.
  - m_wvalid clears on the edge after the cycle in which m_wvalid&m_wready.
  - The two handshakes are independent: either order, or the same cycle.
  - When both are complete, the state moves to RESP and m_bready is set.
  - m_awaddr and m_wdata stay stable while their valid is high.
- RESP:
  - On m_bvalid&m_bready, the edge performs the following: rsp_valid[g] pulses for 1 cycle, rsp_resp is registered from m_bresp, m_bready clears, err_count increments if BRESP is nonzero, and the state returns to IDLE.
- Requester rules:
  - A requester holds req_valid and its payload until it sees req_ready.
  - Only one transaction is in flight at a time.
  - req_valid is ignored outside IDLE.
- err_count saturates at 8'hFF and does not wrap.

## Timing
- Reset values:
  - All outputs 0, including m_awvalid, m_wvalid, m_bready, req_ready, rsp_valid, rsp_resp, err_count, m_awaddr and m_wdata.
  - State is IDLE and ptr is 0.
- Reset mid-transaction: at the next edge with aresetn low, the in-flight write is abandoned with no rsp_valid. The AXI valid outputs drop even if no handshake has occurred.
- Best-case latency, with the slave ready and bvalid arriving on the first RESP cycle:
  - T: accept.
  - T+1: AW and W handshakes.
  - T+2: B handshake.
  - T+3: rsp_valid.
- The block is in IDLE at T+3, so a new grant can occur in the same cycle as rsp_valid. Back-to-back throughput is one write per 3 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle. Priority is the lowest index at or above ptr, wrapping to 0.
- m_bready is never asserted outside RESP. Bvalid outside RESP is ignored.

## Structure
- Package axil_arb_pkg holds:
  - the state enum (IDLE, ADDR_DATA, RESP);
  - response constants RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - ERR_CNT_W = 8.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr, and enable.
  - Outputs: one-hot grant[N] and grant index.
  - It is purely combinational; ptr is held in the parent.
- The top-level module contains the FSM, payload registers, AW/W done flags and err_count.

## Test plan
- Single write: requester 0 writes addr 4'hD, data 32'hCAFE_0001; slave ready, BRESP 00 → m_awaddr=D and m_wdata=CAFE_0001 at T+1, rsp_valid=2'b01 at T+3, rsp_resp=00, err_count=0.
- Contention: both req_valid high from reset; the slave holds bvalid low for 1 cycle → grants in order 0, 1, 0, 1 over four writes; each req_ready is a single-cycle one-hot pulse.
- Split handshakes:
  - m_awready delayed 3 cycles while m_wready is immediate → m_wvalid drops after 1 cycle and m_awvalid is held 3 cycles; RESP is entered only after both handshakes.
  - Then the reverse order.
- Error response: slave returns BRESP 2'b10 on 3 writes → rsp_resp=10 each time, err_count=3; after 300 error writes, err_count stays at 8'hFF.
- Reset mid-operation: aresetn low during ADDR_DATA with m_awready=0 → next edge m_awvalid=m_wvalid=0, no rsp_valid, ptr=0; the first write after reset completes normally.
